// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_pkg
//  Purpose  : Shared defaults and age-distance helper for the common data bus
//             (result broadcast) arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package cdb_pkg;

    localparam int c_NUM_REQ    = 4;
    localparam int c_TAG_W      = 6;
    localparam int c_DATA_W     = 32;
    localparam int c_NUM_W      = 32;
    localparam int c_STARVE_MAX = 7;

    // Unsigned wrap distance of an instruction number from the ROB head;
    // a smaller distance means an older instruction.
    function automatic logic [c_NUM_W-1:0] age_dist(
        input logic [c_NUM_W-1:0] num,
        input logic [c_NUM_W-1:0] head
    );
        return num - head;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_age_select.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_age_select
//  Purpose  : Combinational one-hot selection among occupied result buffers:
//             the lowest-index starved buffer wins, otherwise the oldest
//             instruction wins, with ties resolved to the lowest index.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_age_select
    import cdb_pkg::*;
#(
    parameter int NUM_REQ    = c_NUM_REQ,
    parameter int NUM_W      = c_NUM_W,
    parameter int STARVE_MAX = c_STARVE_MAX,
    parameter int CNT_W      = $clog2(c_STARVE_MAX + 1)
) (
    input  logic [NUM_REQ-1:0]       occ,
    input  logic [NUM_REQ*NUM_W-1:0] num,
    input  logic [NUM_REQ*CNT_W-1:0] cnt,
    input  logic [NUM_W-1:0]         rob_head_num,
    output logic [NUM_REQ-1:0]       sel
);

    localparam logic [CNT_W-1:0] c_STARVE = CNT_W'(STARVE_MAX);

    logic [NUM_REQ-1:0] w_starve_sel;
    logic [NUM_REQ-1:0] w_age_sel;
    logic               w_have_starve;
    logic               w_have_age;
    logic [NUM_W-1:0]   w_best_age;
    logic [NUM_W-1:0]   w_age;

    // Scan buffers in index order so the first hit on either criterion sticks
    always_comb begin
        w_starve_sel  = '0;
        w_age_sel     = '0;
        w_have_starve = 1'b0;
        w_have_age    = 1'b0;
        w_best_age    = '1;
        w_age         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_age = age_dist(num[i*NUM_W +: NUM_W], rob_head_num);
            if (occ[i]) begin
                if (!w_have_starve && (cnt[i*CNT_W +: CNT_W] >= c_STARVE)) begin
                    w_have_starve   = 1'b1;
                    w_starve_sel    = '0;
                    w_starve_sel[i] = 1'b1;
                end
                // Strict less-than keeps the lower index on equal ages
                if (!w_have_age || (w_age < w_best_age)) begin
                    w_have_age   = 1'b1;
                    w_best_age   = w_age;
                    w_age_sel    = '0;
                    w_age_sel[i] = 1'b1;
                end
            end
        end
        sel = w_have_starve ? w_starve_sel : w_age_sel;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Shares the single result broadcast bus among NUM_REQ functional
//             units. Each unit owns a one-entry holding buffer; one buffer is
//             broadcast per cycle, oldest first, with a starvation override.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ    = c_NUM_REQ,
    parameter int TAG_W      = c_TAG_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int NUM_W      = c_NUM_W,
    parameter int STARVE_MAX = c_STARVE_MAX
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      STALL,
    input  logic                      FLUSH,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_val,
    input  logic [NUM_REQ*NUM_W-1:0]  req_num,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_W-1:0]          rob_head_num,
    output logic                      exe_broadcast,
    output logic [TAG_W-1:0]          exe_broadcast_map,
    output logic [DATA_W-1:0]         exe_broadcast_val,
    output logic [NUM_W-1:0]          broadcast_num,
    output logic [NUM_REQ-1:0]        grant_onehot
);

    localparam int               CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_STARVE = CNT_W'(STARVE_MAX);

    // Buffer state
    logic                      r_live;
    logic [NUM_REQ-1:0]        r_occ;
    logic [NUM_REQ*CNT_W-1:0]  r_cnt;
    logic [NUM_REQ*TAG_W-1:0]  r_tag;
    logic [NUM_REQ*DATA_W-1:0] r_val;
    logic [NUM_REQ*NUM_W-1:0]  r_num;

    // Registered broadcast
    logic                      r_bc_valid;
    logic [TAG_W-1:0]          r_bc_tag;
    logic [DATA_W-1:0]         r_bc_val;
    logic [NUM_W-1:0]          r_bc_num;
    logic [NUM_REQ-1:0]        r_grant;

    logic [NUM_REQ-1:0]        w_sel;
    logic [NUM_REQ-1:0]        w_accept;
    logic [NUM_REQ-1:0]        w_tag_nz;
    logic [TAG_W-1:0]          w_bc_tag;
    logic [DATA_W-1:0]         w_bc_val;
    logic [NUM_W-1:0]          w_bc_num;

    cdb_age_select #(
        .NUM_REQ    (NUM_REQ),
        .NUM_W      (NUM_W),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_age_select (
        .occ          (r_occ),
        .num          (r_num),
        .cnt          (r_cnt),
        .rob_head_num (rob_head_num),
        .sel          (w_sel)
    );

    // Handshake: a buffer being drained this cycle may be refilled on the same edge;
    // r_live holds ready low until the first edge after reset release
    always_comb begin
        w_tag_nz = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_tag_nz[i] = |req_tag[i*TAG_W +: TAG_W];
        end
        req_ready = {NUM_REQ{r_live && !STALL && !FLUSH}} & (~r_occ | w_sel);
        w_accept  = req_valid & req_ready;
    end

    // One-hot mux of the granted buffer onto the broadcast bus; zero when idle
    always_comb begin
        w_bc_tag = '0;
        w_bc_val = '0;
        w_bc_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel[i]) begin
                w_bc_tag = r_tag[i*TAG_W  +: TAG_W];
                w_bc_val = r_val[i*DATA_W +: DATA_W];
                w_bc_num = r_num[i*NUM_W  +: NUM_W];
            end
        end
    end

    // Control state: occupancy, starvation counters and registered broadcast
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_live     <= 1'b0;
            r_occ      <= '0;
            r_cnt      <= '0;
            r_bc_valid <= 1'b0;
            r_bc_tag   <= '0;
            r_bc_val   <= '0;
            r_bc_num   <= '0;
            r_grant    <= '0;
        end else begin
            r_live <= 1'b1;
            if (FLUSH) begin
                r_occ      <= '0;
                r_cnt      <= '0;
                r_bc_valid <= 1'b0;
                r_bc_tag   <= '0;
                r_bc_val   <= '0;
                r_bc_num   <= '0;
                r_grant    <= '0;
            end else if (!STALL) begin
                r_bc_valid <= |w_sel;
                r_bc_tag   <= w_bc_tag;
                r_bc_val   <= w_bc_val;
                r_bc_num   <= w_bc_num;
                r_grant    <= w_sel;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_accept[i]) begin
                        // Tag 0 completes the handshake but is never broadcast
                        r_occ[i]                 <= w_tag_nz[i];
                        r_cnt[i*CNT_W +: CNT_W]  <= '0;
                    end else if (w_sel[i] || !r_occ[i]) begin
                        r_occ[i]                 <= 1'b0;
                        r_cnt[i*CNT_W +: CNT_W]  <= '0;
                    end else if (r_cnt[i*CNT_W +: CNT_W] < c_STARVE) begin
                        r_cnt[i*CNT_W +: CNT_W]  <= r_cnt[i*CNT_W +: CNT_W] + 1'b1;
                    end
                end
            end
        end
    end

    // Payload storage; only meaningful while the matching occupancy bit is set
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_tag[i*TAG_W  +: TAG_W]  <= req_tag[i*TAG_W  +: TAG_W];
                r_val[i*DATA_W +: DATA_W] <= req_val[i*DATA_W +: DATA_W];
                r_num[i*NUM_W  +: NUM_W]  <= req_num[i*NUM_W  +: NUM_W];
            end
        end
    end

    assign exe_broadcast     = r_bc_valid;
    assign exe_broadcast_map = r_bc_tag;
    assign exe_broadcast_val = r_bc_val;
    assign broadcast_num     = r_bc_num;
    assign grant_onehot      = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Directed self-checking bench for cdb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;
    localparam int NUM_W   = 32;

    logic                      CLK;
    logic                      RESET;
    logic                      STALL;
    logic                      FLUSH;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_val;
    logic [NUM_REQ*NUM_W-1:0]  req_num;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_W-1:0]          rob_head_num;
    logic                      exe_broadcast;
    logic [TAG_W-1:0]          exe_broadcast_map;
    logic [DATA_W-1:0]         exe_broadcast_val;
    logic [NUM_W-1:0]          broadcast_num;
    logic [NUM_REQ-1:0]        grant_onehot;

    int n_chk;
    int n_err;

    cdb_arbiter u_dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .FLUSH             (FLUSH),
        .req_valid         (req_valid),
        .req_tag           (req_tag),
        .req_val           (req_val),
        .req_num           (req_num),
        .req_ready         (req_ready),
        .rob_head_num      (rob_head_num),
        .exe_broadcast     (exe_broadcast),
        .exe_broadcast_map (exe_broadcast_map),
        .exe_broadcast_val (exe_broadcast_val),
        .broadcast_num     (broadcast_num),
        .grant_onehot      (grant_onehot)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input int u, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] v, input logic [NUM_W-1:0] n);
        req_valid[u]                = 1'b1;
        req_tag[u*TAG_W +: TAG_W]   = t;
        req_val[u*DATA_W +: DATA_W] = v;
        req_num[u*NUM_W +: NUM_W]   = n;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_tag   = '0;
        req_val   = '0;
        req_num   = '0;
    endtask

    task automatic chk_bc(input string tag, input logic b, input logic [TAG_W-1:0] m,
                          input logic [NUM_REQ-1:0] g);
        chk({tag, ".valid"}, 64'(exe_broadcast), 64'(b));
        chk({tag, ".map"},   64'(exe_broadcast_map), 64'(m));
        chk({tag, ".grant"}, 64'(grant_onehot), 64'(g));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        RESET = 1'b0;
        STALL = 1'b0;
        FLUSH = 1'b0;
        rob_head_num = '0;
        clear_reqs();

        // ---------------- reset state ----------------
        #2;
        chk_bc("rst", 1'b0, 6'd0, 4'b0000);
        chk("rst.val", 64'(exe_broadcast_val), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'd0);
        tick();
        RESET = 1'b1;
        #1;
        chk("rel.ready_before_edge", 64'(req_ready), 64'd0);
        tick();
        chk("rel.ready_after_edge", 64'(req_ready), 64'hF);

        // ---------------- single result ----------------
        rob_head_num = 32'd8;
        present(2, 6'd5, 32'hDEAD_BEEF, 32'd10);
        tick();
        clear_reqs();
        chk("single.accept_edge", 64'(exe_broadcast), 64'd0);
        tick();
        chk_bc("single", 1'b1, 6'd5, 4'b0100);
        chk("single.val", 64'(exe_broadcast_val), 64'hDEAD_BEEF);
        chk("single.num", 64'(broadcast_num), 64'd10);
        tick();
        chk_bc("single.after", 1'b0, 6'd0, 4'b0000);
        chk("single.after.val", 64'(exe_broadcast_val), 64'd0);

        // ---------------- age order with wrap ----------------
        rob_head_num = 32'hFFFF_FFFE;
        present(0, 6'd11, 32'h0000_0A00, 32'd3);
        present(1, 6'd12, 32'h0000_0A01, 32'hFFFF_FFFF);
        present(3, 6'd13, 32'h0000_0A03, 32'd1);
        tick();
        clear_reqs();
        tick();
        chk_bc("wrap.1st", 1'b1, 6'd12, 4'b0010);
        tick();
        chk_bc("wrap.2nd", 1'b1, 6'd13, 4'b1000);
        tick();
        chk_bc("wrap.3rd", 1'b1, 6'd11, 4'b0001);
        chk("wrap.3rd.num", 64'(broadcast_num), 64'd3);
        tick();
        chk("wrap.idle", 64'(exe_broadcast), 64'd0);

        // ---------------- starvation + back-to-back refill ----------------
        rob_head_num = 32'd0;
        present(3, 6'd30, 32'h0000_0300, 32'd100);
        present(0, 6'd20, 32'h0000_0200, 32'd1);
        tick();
        req_valid[3] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            present(0, 6'(20 + k), 32'(32'h200 + k), 32'(1 + k));
            #1;
            chk($sformatf("b2b.ready%0d", k), 64'(req_ready[0]), 64'd1);
            tick();
            chk_bc($sformatf("b2b.bc%0d", k), 1'b1, 6'(20 + k - 1), 4'b0001);
        end
        present(0, 6'd28, 32'h0000_0228, 32'd9);
        #1;
        chk("starve.u0_blocked", 64'(req_ready[0]), 64'd0);
        tick();
        chk_bc("starve.u3", 1'b1, 6'd30, 4'b1000);
        chk("starve.u3.num", 64'(broadcast_num), 64'd100);
        tick();
        clear_reqs();
        chk_bc("starve.resume", 1'b1, 6'd27, 4'b0001);
        tick();
        chk_bc("starve.last", 1'b1, 6'd28, 4'b0001);
        tick();
        chk("starve.idle", 64'(exe_broadcast), 64'd0);

        // ---------------- STALL then FLUSH ----------------
        present(1, 6'd40, 32'h0000_0400, 32'd5);
        present(2, 6'd41, 32'h0000_0401, 32'd6);
        tick();
        clear_reqs();
        tick();
        chk_bc("stall.pre", 1'b1, 6'd40, 4'b0010);
        STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_bc($sformatf("stall.hold%0d", k), 1'b1, 6'd40, 4'b0010);
            chk($sformatf("stall.ready%0d", k), 64'(req_ready), 64'd0);
        end
        FLUSH = 1'b1;
        present(0, 6'd50, 32'h0000_0500, 32'd1);
        #1;
        chk("flush.ready", 64'(req_ready), 64'd0);
        tick();
        chk_bc("flush.out", 1'b0, 6'd0, 4'b0000);
        chk("flush.num", 64'(broadcast_num), 64'd0);
        FLUSH = 1'b0;
        STALL = 1'b0;
        clear_reqs();
        tick();
        chk("flush.after1", 64'(exe_broadcast), 64'd0);
        tick();
        chk("flush.after2", 64'(exe_broadcast), 64'd0);

        // ---------------- tag 0 and asynchronous reset ----------------
        present(1, 6'd0, 32'h0000_0600, 32'd1);
        #1;
        chk("tag0.ready", 64'(req_ready[1]), 64'd1);
        tick();
        clear_reqs();
        chk("tag0.ready_after", 64'(req_ready[1]), 64'd1);
        tick();
        chk("tag0.no_bc", 64'(exe_broadcast), 64'd0);
        present(2, 6'd60, 32'h0000_0700, 32'd2);
        present(3, 6'd61, 32'h0000_0701, 32'd3);
        tick();
        clear_reqs();
        tick();
        chk_bc("pre_rst", 1'b1, 6'd60, 4'b0100);
        #2;
        RESET = 1'b0;
        #1;
        chk_bc("async_rst", 1'b0, 6'd0, 4'b0000);
        chk("async_rst.ready", 64'(req_ready), 64'd0);
        tick();
        RESET = 1'b1;
        tick();
        chk("post_rst1", 64'(exe_broadcast), 64'd0);
        tick();
        chk("post_rst2", 64'(exe_broadcast), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
